// File: rtl/hilo_commit_if.sv
// Pipeline and multiply/divide-unit signals of the HI/LO commit block.
// slave is the commit block's view; master is the driving side.
interface hilo_commit_if;
  logic        Start;
  logic        Abort;
  logic [31:0] XALU_HI;
  logic [31:0] XALU_LO;
  logic        XALU_Busy;
  logic        WrHI;
  logic        WrLO;
  logic [31:0] WrData;
  logic        RdHI;
  logic        RdLO;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] RdData;
  logic        Stall;
  logic        Timeout;

  modport slave (
    input  Start, Abort, XALU_HI, XALU_LO, XALU_Busy,
    input  WrHI, WrLO, WrData, RdHI, RdLO,
    output HI, LO, RdData, Stall, Timeout
  );

  modport master (
    output Start, Abort, XALU_HI, XALU_LO, XALU_Busy,
    output WrHI, WrLO, WrData, RdHI, RdLO,
    input  HI, LO, RdData, Stall, Timeout
  );
endinterface

// File: rtl/hilo_commit.sv
// Architectural HI/LO registers: tracks an in-flight mult/div, commits its
// 64-bit result when the unit drops Busy, stalls the pipeline meanwhile.
//
// state | meaning
// IDLE  | no operation in flight; mthi/mtlo writes accepted
// ARM   | one cycle after Start so the unit's Busy can rise
// WAIT  | unit busy; watchdog counting, commit on Busy fall
module hilo_commit #(
  parameter int unsigned WDOG_MAX = 63
) (
  input  logic          Clk,
  input  logic          Clr,
  hilo_commit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  cnt_inc;
  logic        any_req;

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign any_req = bus.RdHI | bus.RdLO | bus.WrHI | bus.WrLO | bus.Start;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.WrHI) hi_d = bus.WrData;
        if (bus.WrLO) lo_d = bus.WrData;
        if (bus.Start && !bus.Abort) begin
          state_d = ARM;
          cnt_d   = 8'd0;
        end
      end

      ARM: begin
        if (bus.Abort) begin
          state_d = IDLE;
        end else if (bus.XALU_Busy) begin
          state_d = WAIT;
        end else begin
          hi_d    = bus.XALU_HI;
          lo_d    = bus.XALU_LO;
          state_d = IDLE;
        end
      end

      WAIT: begin
        if (bus.Abort) begin
          state_d = IDLE;
        end else if (!bus.XALU_Busy) begin
          hi_d    = bus.XALU_HI;
          lo_d    = bus.XALU_LO;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          // Watchdog is only a flag; the unit is still waited on.
          if (32'(cnt_inc) >= WDOG_MAX) timeout_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q   <= IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.RdData  = bus.RdHI ? hi_q : lo_q;
  assign bus.Stall   = (state_q != IDLE) && any_req;
  assign bus.Timeout = timeout_q;

endmodule

// File: tb/tb_hilo_commit.sv
// Directed bench for hilo_commit: a vector table for single-cycle behaviour
// plus hand-written sequences for commit latency, abort, watchdog and reset.
module tb_hilo_commit;
  localparam int unsigned WDOG = 63;

  logic Clk;
  logic Clr;
  hilo_commit_if bus ();

  hilo_commit #(.WDOG_MAX(WDOG)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        start, abort, busy, wrhi, wrlo, rdhi, rdlo;
    logic [31:0] xhi, xlo, wdata;
    logic        exp_stall;
    logic [31:0] exp_rd, exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic quiet();
    Clr           = 1'b0;
    bus.Start     = 1'b0;
    bus.Abort     = 1'b0;
    bus.XALU_HI   = 32'd0;
    bus.XALU_LO   = 32'd0;
    bus.XALU_Busy = 1'b0;
    bus.WrHI      = 1'b0;
    bus.WrLO      = 1'b0;
    bus.WrData    = 32'd0;
    bus.RdHI      = 1'b0;
    bus.RdLO      = 1'b0;
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, a, b, wh, wl, rh, rl,
                              input logic [31:0] xh, xl, wd,
                              input logic es, input logic [31:0] er, eh, el);
    vec_t v;
    v.start = s;  v.abort = a; v.busy = b; v.wrhi = wh; v.wrlo = wl;
    v.rdhi = rh;  v.rdlo = rl; v.xhi = xh; v.xlo = xl; v.wdata = wd;
    v.exp_stall = es; v.exp_rd = er; v.exp_hi = eh; v.exp_lo = el;
    return v;
  endfunction

  initial begin
    //            st ab by wh wl rh rl  xhi           xlo           wdata         stl rd            hi            lo
    vecs[0]  = mk(0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h11111111, 0, 32'h00000000, 32'h11111111, 32'h00000000);
    vecs[1]  = mk(0, 0, 0, 0, 1, 1, 0, 32'h0,        32'h0,        32'h22222222, 0, 32'h11111111, 32'h11111111, 32'h22222222);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,        0, 32'h11111111, 32'h11111111, 32'h22222222);
    vecs[3]  = mk(0, 0, 0, 1, 1, 0, 1, 32'h0,        32'h0,        32'hCAFEBABE, 0, 32'h22222222, 32'hCAFEBABE, 32'hCAFEBABE);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 32'hAAAA0001, 32'hBBBB0002, 32'h0,        0, 32'hCAFEBABE, 32'hCAFEBABE, 32'hCAFEBABE);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hAAAA0001, 32'hBBBB0002, 32'h0,        1, 32'hCAFEBABE, 32'hAAAA0001, 32'hBBBB0002);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 32'hBBBB0002, 32'hAAAA0001, 32'hBBBB0002);
    vecs[7]  = mk(1, 0, 0, 1, 0, 0, 0, 32'h44444444, 32'h55555555, 32'h33333333, 0, 32'hBBBB0002, 32'h33333333, 32'hBBBB0002);
    vecs[8]  = mk(1, 0, 1, 0, 1, 0, 0, 32'h44444444, 32'h55555555, 32'h66666666, 1, 32'hBBBB0002, 32'h33333333, 32'hBBBB0002);
    vecs[9]  = mk(0, 0, 1, 0, 0, 1, 0, 32'h44444444, 32'h55555555, 32'h0,        1, 32'h33333333, 32'h33333333, 32'hBBBB0002);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 32'h44444444, 32'h55555555, 32'h0,        0, 32'hBBBB0002, 32'h44444444, 32'h55555555);
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        0, 32'h44444444, 32'h44444444, 32'h55555555);
    vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h55555555, 32'h44444444, 32'h55555555);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 32'h55555555, 32'h44444444, 32'h55555555);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 32'h77777777, 32'h88888888, 32'h0,        0, 32'h55555555, 32'h44444444, 32'h55555555);
    vecs[15] = mk(0, 1, 0, 0, 0, 0, 0, 32'h77777777, 32'h88888888, 32'h0,        0, 32'h55555555, 32'h44444444, 32'h55555555);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 32'h55555555, 32'h44444444, 32'h55555555);

    // Reset
    quiet();
    Clr = 1'b1;
    cycle();
    cycle();
    bus.RdHI = 1'b1;
    #1;
    chk("rst_stall", 32'(bus.Stall), 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    chk("rst_timeout", 32'(bus.Timeout), 32'd0);
    quiet();
    cycle();

    // Vector table
    for (int i = 0; i < 17; i++) begin
      bus.Start     = vecs[i].start;
      bus.Abort     = vecs[i].abort;
      bus.XALU_Busy = vecs[i].busy;
      bus.WrHI      = vecs[i].wrhi;
      bus.WrLO      = vecs[i].wrlo;
      bus.RdHI      = vecs[i].rdhi;
      bus.RdLO      = vecs[i].rdlo;
      bus.XALU_HI   = vecs[i].xhi;
      bus.XALU_LO   = vecs[i].xlo;
      bus.WrData    = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(bus.Stall), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_rddata", i), bus.RdData, vecs[i].exp_rd);
      cycle();
      chk($sformatf("vec%0d_hi", i), bus.HI, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), bus.LO, vecs[i].exp_lo);
      chk($sformatf("vec%0d_timeout", i), 32'(bus.Timeout), 32'd0);
    end
    quiet();
    cycle();

    // Busy high 3 cycles with a concurrent mflo stalling until commit
    bus.Start = 1'b1; bus.RdLO = 1'b1;
    bus.XALU_HI = 32'h00000001; bus.XALU_LO = 32'hFFFFFFFE;
    #1;
    chk("mul_start_stall", 32'(bus.Stall), 32'd0);
    cycle();
    bus.Start = 1'b0; bus.XALU_Busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mul_busy%0d_stall", k), 32'(bus.Stall), 32'd1);
      cycle();
    end
    bus.XALU_Busy = 1'b0;
    #1;
    chk("mul_fall_stall", 32'(bus.Stall), 32'd1);
    chk("mul_fall_lo_old", bus.LO, 32'h55555555);
    cycle();
    chk("mul_done_stall", 32'(bus.Stall), 32'd0);
    chk("mul_done_rddata", bus.RdData, 32'hFFFFFFFE);
    chk("mul_done_hi", bus.HI, 32'h00000001);
    quiet();
    cycle();

    // Abort in the second WAIT cycle; write in WAIT ignored
    bus.WrHI = 1'b1; bus.WrData = 32'h12345678;
    cycle();
    bus.WrHI = 1'b0; bus.WrLO = 1'b1; bus.WrData = 32'h9ABCDEF0;
    cycle();
    quiet();
    bus.Start = 1'b1; bus.XALU_HI = 32'h01010101; bus.XALU_LO = 32'h02020202;
    cycle();
    bus.Start = 1'b0; bus.XALU_Busy = 1'b1;
    cycle();
    bus.WrHI = 1'b1; bus.WrLO = 1'b1; bus.WrData = 32'hCAFEBABE;
    #1;
    chk("wait_write_stall", 32'(bus.Stall), 32'd1);
    cycle();
    chk("wait_write_hi", bus.HI, 32'h12345678);
    chk("wait_write_lo", bus.LO, 32'h9ABCDEF0);
    bus.WrHI = 1'b0; bus.WrLO = 1'b0;
    bus.Abort = 1'b1;
    cycle();
    quiet();
    bus.RdLO = 1'b1;
    #1;
    chk("abort_stall", 32'(bus.Stall), 32'd0);
    chk("abort_hi", bus.HI, 32'h12345678);
    chk("abort_lo", bus.LO, 32'h9ABCDEF0);
    cycle();
    chk("abort_no_late_lo", bus.LO, 32'h9ABCDEF0);
    quiet();

    // Watchdog: Busy high for WDOG+2 cycles, commit still happens
    bus.Start = 1'b1; bus.XALU_HI = 32'hDEADBEEF; bus.XALU_LO = 32'h0BADF00D;
    cycle();
    bus.Start = 1'b0; bus.XALU_Busy = 1'b1;
    cycle();
    for (int n = 1; n <= int'(WDOG) + 1; n++) begin
      cycle();
      chk($sformatf("wdog_n%0d", n), 32'(bus.Timeout), (n >= int'(WDOG)) ? 32'd1 : 32'd0);
    end
    bus.XALU_Busy = 1'b0;
    cycle();
    chk("wdog_commit_hi", bus.HI, 32'hDEADBEEF);
    chk("wdog_commit_lo", bus.LO, 32'h0BADF00D);
    quiet();
    for (int k = 0; k < 3; k++) cycle();
    chk("wdog_sticky", 32'(bus.Timeout), 32'd1);
    Clr = 1'b1;
    bus.RdHI = 1'b1;
    #1;
    chk("clr_stall", 32'(bus.Stall), 32'd0);
    cycle();
    chk("clr_timeout", 32'(bus.Timeout), 32'd0);
    chk("clr_hi", bus.HI, 32'd0);
    chk("clr_stall_after", 32'(bus.Stall), 32'd0);
    quiet();
    cycle();

    // Clr in the same cycle Busy falls in WAIT discards the result
    bus.WrHI = 1'b1; bus.WrLO = 1'b1; bus.WrData = 32'hA5A5A5A5;
    cycle();
    quiet();
    chk("pre_clr_lo", bus.LO, 32'hA5A5A5A5);
    bus.Start = 1'b1; bus.XALU_HI = 32'h13579BDF; bus.XALU_LO = 32'h2468ACE0;
    cycle();
    bus.Start = 1'b0; bus.XALU_Busy = 1'b1;
    cycle();
    cycle();
    bus.XALU_Busy = 1'b0; Clr = 1'b1;
    cycle();
    Clr = 1'b0;
    bus.RdHI = 1'b1;
    #1;
    chk("clrfall_hi", bus.HI, 32'd0);
    chk("clrfall_lo", bus.LO, 32'd0);
    chk("clrfall_stall", 32'(bus.Stall), 32'd0);
    cycle();
    chk("clrfall_no_late_hi", bus.HI, 32'd0);
    chk("clrfall_timeout", 32'(bus.Timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_commit.md
HILO_COMMIT -- requirements
Module: hilo_commit

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 63, meaning the maximum number of cycles tolerated in WAIT before the timeout flag is raised.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Clr, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Start, input, 1, a mult/multu/div/divu issue pulse, identical to the multiply/divide unit's start.
REQ-005 SHALL have port Abort, input, 1, an interrupt/flush that cancels an in-flight operation.
REQ-006 SHALL have port XALU_HI, input, 32, the multiply/divide unit's HI result.
REQ-007 SHALL have port XALU_LO, input, 32, the multiply/divide unit's LO result.
REQ-008 SHALL have port XALU_Busy, input, 1, the multiply/divide unit's busy flag.
REQ-009 SHALL have port WrHI, input, 1, an mthi write request.
REQ-010 SHALL have port WrLO, input, 1, an mtlo write request.
REQ-011 SHALL have port WrData, input, 32, the mthi/mtlo data.
REQ-012 SHALL have port RdHI, input, 1, an mfhi request.
REQ-013 SHALL have port RdLO, input, 1, an mflo request.
REQ-014 SHALL have port HI, output, 32, the architectural HI register.
REQ-015 SHALL have port LO, output, 32, the architectural LO register.
REQ-016 SHALL have port RdData, output, 32, equal to RdHI ? HI : LO (combinational, registers only).
REQ-017 SHALL have port Stall, output, 1, a pipeline hold request.
REQ-018 SHALL have port Timeout, output, 1, a sticky watchdog flag.

Function
REQ-019 SHALL implement three states: IDLE, ARM, WAIT.
REQ-020 IDLE: Start && !Abort -> ARM; the wait counter is cleared.
REQ-021 ARM: one cycle to let Busy rise; Abort -> IDLE with no commit; else XALU_Busy=1 -> WAIT; else commit XALU_HI/LO into HI/LO at this edge -> IDLE.
REQ-022 WAIT: Abort -> IDLE with no commit; else XALU_Busy=0 -> commit XALU_HI/LO into HI/LO -> IDLE; else stay in WAIT and increment the counter.
REQ-023 The commit takes effect at the edge leaving ARM/WAIT; the new value is visible on HI/LO/RdData in the following IDLE cycle.
REQ-024 Stall SHALL equal (state != IDLE) && (RdHI | RdLO | WrHI | WrLO | Start), combinational.
REQ-025 In IDLE, WrHI loads HI and WrLO loads LO from WrData at the edge; both may assert together, loading the same data into both.
REQ-026 Writes while stalled SHALL be ignored; the pipeline reissues them.
REQ-027 In IDLE, a simultaneous Start and WrHI/WrLO SHALL apply the write and enter ARM; the later commit overwrites the written value.
REQ-028 RdHI and RdLO asserted together SHALL return HI.
REQ-029 Start in ARM/WAIT SHALL be ignored (Stall is high).
REQ-030 Abort has priority over both commit and Busy evaluation in the same cycle.
REQ-031 The counter SHALL be 8 bits and saturate at 255.
REQ-032 When the counter reaches WDOG_MAX in WAIT, Timeout SHALL be set and remain set until Clr; the state machine keeps waiting.
REQ-033 Commits SHALL copy the full 64 bits unmodified, with no sign handling in this block.

Reset
REQ-034 Clr=1 at a clock edge SHALL force state to IDLE, HI=0, LO=0, counter=0, and Timeout=0, overriding every other input.
REQ-035 Clr mid-operation (ARM/WAIT) SHALL discard the pending result; no commit occurs, even if Busy falls in that cycle.
REQ-036 During and after Clr, Stall=0 while in IDLE.

Verification
REQ-037 Start, Busy high 3 cycles then low with XALU_HI=0x00000001, XALU_LO=0xFFFFFFFE -> HI/LO take those values the cycle after Busy falls; a concurrent RdLO stalls each cycle until then, then RdData=0xFFFFFFFE.
REQ-038 Start with Busy never high -> commit from ARM after 1 cycle; the state returns to IDLE 2 cycles after Start.
REQ-039 Start, then Abort in the 2nd WAIT cycle, with HI/LO previously 0x12345678/0x9ABCDEF0 -> values unchanged, state IDLE, Stall=0.
REQ-040 IDLE, WrHI=WrLO=1, WrData=0xCAFEBABE -> HI=LO=0xCAFEBABE; the same write in WAIT -> Stall=1 and the registers unchanged.
REQ-041 Busy held high for WDOG_MAX+2 cycles -> Timeout=1 from cycle WDOG_MAX; commit still occurs on the Busy fall; Timeout stays 1 until Clr.
REQ-042 Clr asserted in the same cycle Busy falls in WAIT -> HI=LO=0, no commit, state IDLE.
